sb_tsm_d2: RTL and testbench

//  Second-order masked PRINCE 4-bit S-box, 3 Boolean shares, domain-oriented (DOM-indep) multipliers.

---
 rtl/sb_tsm_d2.sv | 214 +++++++++++++++++++++
 tb/tb_sb_tsm_d2.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sb_tsm_d2.sv
// rtl/sb_tsm_d2.sv - second-order masked PRINCE S-box, 3 shares, DOM-indep, 3-stage pipeline
//
// Computes S(x) = {B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4}[x] on three Boolean shares
// (x = inp_sh0 ^ inp_sh1 ^ inp_sh2) through its algebraic normal form:
//   y0 = 1 ^ x2 ^ x3 ^ x0x1 ^ x1x2 ^ x0x3 ^ x2x3 ^ x0x1x2
//   y1 = 1 ^ x0x2 ^ x1x2 ^ x1x3 ^ x0x1x2 ^ x1x2x3
//   y2 = x0 ^ x3 ^ x0x1 ^ x0x3 ^ x1x3 ^ x0x1x3 ^ x1x2x3
//   y3 = 1 ^ x1 ^ x3 ^ x1x2 ^ x2x3 ^ x0x1x2 ^ x0x1x3 ^ x0x2x3
// Latency 3 clocks, one new input per clock, 54 fresh random bits per clock.
//
// Ports:
//   clk                      rising-edge clock
//   rst                      synchronous active-high reset, clears all pipeline state
//   PRNG[53:0]               fresh randomness, new value every cycle
//   inp_sh0/1/2[3:0]         input shares
//   F_sh0/1/2[3:0]           registered output shares, XOR equals S(x)
//
// Build option: SB_OUT_REFRESH_EN adds a final share refresh from PRNG[53:46].

module sb_tsm_d2 (
  input  logic        clk,
  input  logic        rst,
  input  logic [53:0] PRNG,
  input  logic [3:0]  inp_sh0,
  input  logic [3:0]  inp_sh1,
  input  logic [3:0]  inp_sh2,
  output logic [3:0]  F_sh0,
  output logic [3:0]  F_sh1,
  output logic [3:0]  F_sh2
);

  // DOM-indep product terms, z[3*i+j] belongs to domain i.
  // r[0], r[1], r[2] blind the cross pairs (0,1), (0,2), (1,2).
  function automatic logic [8:0] dom_terms(input logic [2:0] a, input logic [2:0] b,
                                           input logic [2:0] r);
    logic [8:0] z;
    z[0] = a[0] & b[0];
    z[1] = (a[0] & b[1]) ^ r[0];
    z[2] = (a[0] & b[2]) ^ r[1];
    z[3] = (a[1] & b[0]) ^ r[0];
    z[4] = a[1] & b[1];
    z[5] = (a[1] & b[2]) ^ r[2];
    z[6] = (a[2] & b[0]) ^ r[1];
    z[7] = (a[2] & b[1]) ^ r[2];
    z[8] = a[2] & b[2];
    return z;
  endfunction

  // Compression only ever runs on registered terms, so no glitch mixes domains.
  function automatic logic [2:0] dom_compress(input logic [8:0] z);
    return {z[6] ^ z[7] ^ z[8], z[3] ^ z[4] ^ z[5], z[0] ^ z[1] ^ z[2]};
  endfunction

  function automatic logic [2:0] refresh3(input logic [2:0] v, input logic a, input logic b);
    return {v[2] ^ a ^ b, v[1] ^ b, v[0] ^ a};
  endfunction

  // Quadratic gadget k: 0:x0x1 1:x0x2 2:x0x3 3:x1x2 4:x1x3 5:x2x3
  function automatic logic [1:0] pair_a(input int k);
    case (k)
      0, 1, 2: return 2'd0;
      3, 4:    return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] pair_b(input int k);
    case (k)
      0:       return 2'd1;
      1, 3:    return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Shares regrouped per bit: x_in[i] = {sh2[i], sh1[i], sh0[i]}
  logic [2:0] x_in [4];

  // Stage 1 state
  logic [8:0] g1_q   [6];
  logic [2:0] lin1_q [4];
  logic       v1_q;

  // Stage 2 state
  logic [2:0] quad2_q [6];
  logic [8:0] cub2_q  [4];
  logic [2:0] lin2_q  [4];
  logic       v2_q;

  // Combinational next-state
  logic [8:0] g1_d   [6];
  logic [2:0] lin1_d [4];
  logic [2:0] q_cmp  [6];
  logic [2:0] q_ref  [6];
  logic [8:0] cub2_d [4];
  logic [2:0] c_cmp  [4];
  logic [3:0] y_sh   [3];
  logic [3:0] y_out  [3];
  logic [3:0] ref_a;
  logic [3:0] ref_b;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      x_in[i] = {inp_sh2[i], inp_sh1[i], inp_sh0[i]};
    end
  end

  // Stage 1: quadratic DOM gadgets and refreshed linear shares
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      g1_d[k] = dom_terms(x_in[pair_a(k)], x_in[pair_b(k)], PRNG[3*k +: 3]);
    end
    for (int i = 0; i < 4; i++) begin
      lin1_d[i] = refresh3(x_in[i], PRNG[18 + 2*i], PRNG[19 + 2*i]);
    end
  end

  // Stage 2: compress quadratics, refresh the four that feed cubic gadgets,
  // then multiply by the delayed linear shares
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      q_cmp[k] = dom_compress(g1_q[k]);
    end
    q_ref[0] = refresh3(q_cmp[0], PRNG[26], PRNG[27]);
    q_ref[1] = refresh3(q_cmp[1], PRNG[28], PRNG[29]);
    q_ref[2] = q_cmp[2];
    q_ref[3] = refresh3(q_cmp[3], PRNG[30], PRNG[31]);
    q_ref[4] = refresh3(q_cmp[4], PRNG[32], PRNG[33]);
    q_ref[5] = q_cmp[5];
    cub2_d[0] = dom_terms(q_ref[0], lin1_q[2], PRNG[36:34]);  // x0x1x2
    cub2_d[1] = dom_terms(q_ref[0], lin1_q[3], PRNG[39:37]);  // x0x1x3
    cub2_d[2] = dom_terms(q_ref[1], lin1_q[3], PRNG[42:40]);  // x0x2x3
    cub2_d[3] = dom_terms(q_ref[3], lin1_q[3], PRNG[45:43]);  // x1x2x3
  end

  // Stage 3: per-domain ANF sums; the constant 0xB lands in domain 0 only
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      c_cmp[j] = dom_compress(cub2_q[j]);
    end
    for (int d = 0; d < 3; d++) begin
      y_sh[d][0] = lin2_q[2][d] ^ lin2_q[3][d] ^ quad2_q[0][d] ^ quad2_q[3][d]
                 ^ quad2_q[2][d] ^ quad2_q[5][d] ^ c_cmp[0][d];
      y_sh[d][1] = quad2_q[1][d] ^ quad2_q[3][d] ^ quad2_q[4][d]
                 ^ c_cmp[0][d] ^ c_cmp[3][d];
      y_sh[d][2] = lin2_q[0][d] ^ lin2_q[3][d] ^ quad2_q[0][d] ^ quad2_q[2][d]
                 ^ quad2_q[4][d] ^ c_cmp[1][d] ^ c_cmp[3][d];
      y_sh[d][3] = lin2_q[1][d] ^ lin2_q[3][d] ^ quad2_q[3][d] ^ quad2_q[5][d]
                 ^ c_cmp[0][d] ^ c_cmp[1][d] ^ c_cmp[2][d];
    end
  end

`ifdef SB_OUT_REFRESH_EN
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ref_a[i] = PRNG[46 + 2*i];
      ref_b[i] = PRNG[47 + 2*i];
    end
  end
`else
  logic unused_prng_hi;
  assign unused_prng_hi = ^PRNG[53:46];
  assign ref_a = 4'h0;
  assign ref_b = 4'h0;
`endif

  always_comb begin
    y_out[0] = y_sh[0] ^ 4'hB ^ ref_a;
    y_out[1] = y_sh[1] ^ ref_b;
    y_out[2] = y_sh[2] ^ ref_a ^ ref_b;
  end

  // The valid bits keep the outputs at zero until real data reaches stage 3;
  // otherwise the cleared pipeline would present S(0)=0xB right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 6; k++) begin
        g1_q[k]    <= '0;
        quad2_q[k] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        lin1_q[i] <= '0;
        lin2_q[i] <= '0;
        cub2_q[i] <= '0;
      end
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      F_sh0 <= '0;
      F_sh1 <= '0;
      F_sh2 <= '0;
    end else begin
      for (int k = 0; k < 6; k++) begin
        g1_q[k]    <= g1_d[k];
        quad2_q[k] <= q_ref[k];
      end
      for (int i = 0; i < 4; i++) begin
        lin1_q[i] <= lin1_d[i];
        lin2_q[i] <= lin1_q[i];
        cub2_q[i] <= cub2_d[i];
      end
      v1_q <= 1'b1;
      v2_q <= v1_q;
      if (v2_q) begin
        F_sh0 <= y_out[0];
        F_sh1 <= y_out[1];
        F_sh2 <= y_out[2];
      end else begin
        F_sh0 <= '0;
        F_sh1 <= '0;
        F_sh2 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sb_tsm_d2.sv
// tb/tb_sb_tsm_d2.sv - directed and randomised checks for sb_tsm_d2

module tb_sb_tsm_d2;

  logic        clk = 1'b0;
  logic        rst;
  logic [53:0] prng;
  logic [3:0]  s0, s1, s2;
  logic [3:0]  f0, f1, f2;

  always #5 clk = ~clk;

  sb_tsm_d2 dut (
    .clk     (clk),
    .rst     (rst),
    .PRNG    (prng),
    .inp_sh0 (s0),
    .inp_sh1 (s1),
    .inp_sh2 (s2),
    .F_sh0   (f0),
    .F_sh1   (f1),
    .F_sh2   (f2)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] sbox [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                            4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};

  // Latency model: input applied before edge N is expected after edge N+2
  logic       m1_v = 1'b0, m2_v = 1'b0, mo_v = 1'b0;
  logic [3:0] m1_x = '0, m2_x = '0, mo_y = '0;

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [53:0] rnd54();
    return {22'($urandom), 32'($urandom)};
  endfunction

  task automatic step(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                      input logic [53:0] r, input logic rs, input logic chk, input string tag);
    s0 = a0; s1 = a1; s2 = a2; prng = r; rst = rs;
    @(posedge clk);
    if (rs) begin
      m1_v = 1'b0; m2_v = 1'b0; mo_v = 1'b0; mo_y = 4'h0;
    end else begin
      mo_v = m2_v;
      mo_y = m2_v ? sbox[m2_x] : 4'h0;
      m2_v = m1_v; m2_x = m1_x;
      m1_v = 1'b1; m1_x = a0 ^ a1 ^ a2;
    end
    #1;
    if (chk) begin
      check_val(tag, f0 ^ f1 ^ f2, mo_y);
      if (!mo_v) check_val({tag, "_zero"}, f0 | f1 | f2, 4'h0);
    end
  endtask

  logic [63:0] t2_exp = 64'hBF32AC916780E5D4;
  logic [3:0]  t4x [8], t4a [8], t4b [8];
  logic [3:0]  run_s0 [2][8];
  logic [3:0]  xv, av, bv;
  int          diff_cnt;

  initial begin
    // 1. reset state and first result
    step(4'h0, 4'h0, 4'h0, rnd54(), 1'b1, 1'b0, "");
    step(4'h0, 4'h0, 4'h0, rnd54(), 1'b1, 1'b0, "");
    check_val("rst_sh0", f0, 4'h0);
    check_val("rst_sh1", f1, 4'h0);
    check_val("rst_sh2", f2, 4'h0);
    step(4'h0, 4'h0, 4'h0, rnd54(), 1'b0, 1'b0, "");
    check_val("t1_edge1", f0 ^ f1 ^ f2, 4'h0);
    step(4'h0, 4'h0, 4'h0, rnd54(), 1'b0, 1'b0, "");
    check_val("t1_edge2", f0 ^ f1 ^ f2, 4'h0);
    step(4'h0, 4'h0, 4'h0, rnd54(), 1'b0, 1'b0, "");
    check_val("t1_edge3", f0 ^ f1 ^ f2, 4'hB);

    // 2. shares (0,0,c), hand table of S
    for (int c = 0; c < 18; c++) begin
      step(4'h0, 4'h0, (c < 16) ? 4'(c) : 4'h0, rnd54(), 1'b0, 1'b1, "t2_model");
      if (c >= 2) check_val("t2_table", f0 ^ f1 ^ f2, t2_exp[63 - 4*(c-2) -: 4]);
    end

    // 3. random splits, random PRNG
    for (int n = 0; n < 10000; n++) begin
      xv = 4'($urandom); av = 4'($urandom); bv = 4'($urandom);
      step(av, bv, xv ^ av ^ bv, rnd54(), 1'b0, 1'b1, "t3_rand");
    end

    // 4. same inputs with PRNG zero and random
    for (int i = 0; i < 8; i++) begin
      t4x[i] = 4'($urandom); t4a[i] = 4'($urandom); t4b[i] = 4'($urandom);
    end
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 10; n++) begin
        if (n < 8) step(t4a[n], t4b[n], t4x[n] ^ t4a[n] ^ t4b[n],
                        (r == 0) ? 54'd0 : rnd54(), 1'b0, 1'b1, "t4_model");
        else       step(4'h0, 4'h0, 4'h0, 54'd0, 1'b0, 1'b1, "t4_model");
        if (n >= 2) begin
          check_val("t4_unmasked", f0 ^ f1 ^ f2, sbox[t4x[n-2]]);
          run_s0[r][n-2] = f0;
        end
      end
    end
    diff_cnt = 0;
    for (int i = 0; i < 8; i++) if (run_s0[0][i] != run_s0[1][i]) diff_cnt++;
    check_val("t4_share_diff", {3'b0, diff_cnt != 0}, 4'h1);

    // 5. one-cycle reset mid-stream
    for (int c = 0; c < 16; c++) begin
      step(4'h3, 4'h5, 4'(c) ^ 4'h3 ^ 4'h5, rnd54(), (c == 8), 1'b1, "t5_stream");
      if (c == 8) check_val("t5_rst_zero", f0 | f1 | f2, 4'h0);
      if (c == 11) check_val("t5_resume", f0 ^ f1 ^ f2, sbox[9]);
    end
    for (int n = 0; n < 3; n++) step(4'h0, 4'h0, 4'h0, rnd54(), 1'b0, 1'b1, "t5_flush");

    // 6. output refresh behaviour, everything else deterministic
    for (int n = 0; n < 3; n++) step(4'h5, 4'h0, 4'h0, 54'd0, 1'b0, 1'b1, "t6_model");
    check_val("t6_sh0_plain", f0, 4'hC);
    check_val("t6_sh1_plain", f1, 4'h0);
    check_val("t6_sh2_plain", f2, 4'h0);
    step(4'h5, 4'h0, 4'h0, {8'hFF, 46'd0}, 1'b0, 1'b1, "t6_model");
`ifdef SB_OUT_REFRESH_EN
    check_val("t6_sh0_ref", f0, 4'h3);
    check_val("t6_sh1_ref", f1, 4'hF);
    check_val("t6_sh2_ref", f2, 4'h0);
`else
    check_val("t6_sh0_ref", f0, 4'hC);
    check_val("t6_sh1_ref", f1, 4'h0);
    check_val("t6_sh2_ref", f2, 4'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
